// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit for the E stage: fixed-latency MULT/DIV with atomic commit and cancel.
// Define MULDIV_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate ops (otherwise they are NOPs).
module muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MULDIV_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [2*WIDTH-1:0] res_q;
`ifdef MULDIV_MADD_EN
  logic               acc_q, sub_q;
  logic               acc_d, sub_d;
`endif

  logic               is_mult, is_div, mul_signed, div_signed;
  logic [2*WIDTH-1:0] a_x, b_x, prod, res_d, commit_d;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b, uq, ur, q, r;

  always_comb begin
    is_mult    = 1'b0;
    is_div     = 1'b0;
    mul_signed = 1'b0;
    div_signed = 1'b0;
`ifdef MULDIV_MADD_EN
    acc_d      = 1'b0;
    sub_d      = 1'b0;
`endif
    case (op)
      OP_MULT:  begin is_mult = 1'b1; mul_signed = 1'b1; end
      OP_MULTU: is_mult = 1'b1;
      OP_DIV:   begin is_div = 1'b1; div_signed = 1'b1; end
      OP_DIVU:  is_div = 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MADD:  begin is_mult = 1'b1; mul_signed = 1'b1; acc_d = 1'b1; end
      OP_MADDU: begin is_mult = 1'b1; acc_d = 1'b1; end
      OP_MSUB:  begin is_mult = 1'b1; mul_signed = 1'b1; acc_d = 1'b1; sub_d = 1'b1; end
      OP_MSUBU: begin is_mult = 1'b1; acc_d = 1'b1; sub_d = 1'b1; end
`endif
      default: ;
    endcase
  end

  // One 2W-bit multiplier serves both signednesses via operand extension.
  assign a_x  = {{WIDTH{mul_signed & in_a[WIDTH-1]}}, in_a};
  assign b_x  = {{WIDTH{mul_signed & in_b[WIDTH-1]}}, in_b};
  assign prod = a_x * b_x;

  // Sign-magnitude divide; MIN / -1 wraps through the negations to quotient MIN, remainder 0.
  assign a_neg = div_signed & in_a[WIDTH-1];
  assign b_neg = div_signed & in_b[WIDTH-1];
  assign abs_a = a_neg ? (~in_a + WIDTH'(1)) : in_a;
  assign abs_b = b_neg ? (~in_b + WIDTH'(1)) : in_b;
  assign uq    = abs_a / abs_b;
  assign ur    = abs_a % abs_b;
  assign q     = (a_neg ^ b_neg) ? (~uq + WIDTH'(1)) : uq;
  assign r     = a_neg ? (~ur + WIDTH'(1)) : ur;

  always_comb begin
    res_d = prod;
    if (is_div) begin
      if (in_b == '0) res_d = {in_a, {WIDTH{1'b1}}};
      else            res_d = {r, q};
    end
  end

`ifdef MULDIV_MADD_EN
  assign commit_d = !acc_q ? res_q :
                    sub_q  ? ({hi_q, lo_q} - res_q) : ({hi_q, lo_q} + res_q);
`else
  assign commit_d = res_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
`ifdef MULDIV_MADD_EN
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !cancel) begin
            if (is_mult || is_div) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              cnt_q   <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              res_q   <= res_d;
`ifdef MULDIV_MADD_EN
              acc_q   <= acc_d;
              sub_q   <= sub_d;
`endif
            end else if (op == OP_MTHI) begin
              hi_q <= in_a;
            end else if (op == OP_MTLO) begin
              lo_q <= in_a;
            end
          end
        end
        RUN: begin
          if (cancel) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
              state_q      <= IDLE;
              busy_q       <= 1'b0;
              {hi_q, lo_q} <= commit_d;
            end
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
